// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//
// Purpose:
//   Filters bouncy, already-synchronized inputs one channel at a time. One
//   free-running counter, shared by all channels, produces a sample strobe
//   every SAMPLE_CNT_MAX cycles. Each channel counts consecutive strobes
//   during which its input is high, and it saturates at PULSE_CNT_MAX. The
//   filtered output is high only while the channel counter is saturated.
//   Any low cycle on the input clears that channel's counter at once, so the
//   output releases one cycle after the input falls. Only the press is
//   filtered.
//
// Parameters:
//   WIDTH          number of independent channels
//   SAMPLE_CNT_MAX clock cycles per sample period (>= 2)
//   PULSE_CNT_MAX  consecutive high samples needed to assert (>= 1)
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   glitchy_signal   [WIDTH] raw inputs, already synchronized to clk
//   debounced_signal [WIDTH] filtered level per channel
//   rising_pulse     [WIDTH] one-cycle pulse on each debounced 0->1
//   falling_pulse    [WIDTH] one-cycle pulse on each debounced 1->0
//
// Configuration macro:
//   DEBOUNCER_EDGE_EN  when defined, the edge pulses are generated from a
//                      registered copy of debounced_signal. When undefined,
//                      rising_pulse and falling_pulse are tied to 0.
// -----------------------------------------------------------------------------
module debouncer #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rising_pulse,
  output logic [WIDTH-1:0] falling_pulse
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX);
  localparam int PW = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] PULSE_FULL  = PW'(PULSE_CNT_MAX);

  logic [SW-1:0] r_sampleCnt;
  logic          w_samplePulse;
  logic [PW-1:0] r_pulseCnt [WIDTH];

  // The strobe decodes the last count of the period, so it is high for
  // exactly one cycle in every SAMPLE_CNT_MAX cycles.
  assign w_samplePulse = (r_sampleCnt == SAMPLE_LAST);

  // Shared sample-period counter. It wraps on the strobe itself, so the
  // period is SAMPLE_CNT_MAX even when that value is not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sampleCnt <= '0;
    end else if (w_samplePulse) begin
      r_sampleCnt <= '0;
    end else begin
      r_sampleCnt <= r_sampleCnt + SW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    // A low input clears the counter before the strobe is looked at. A glitch
    // that lands on a sample cycle therefore still restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pulseCnt[i] <= '0;
      end else if (!glitchy_signal[i]) begin
        r_pulseCnt[i] <= '0;
      end else if (w_samplePulse && (r_pulseCnt[i] < PULSE_FULL)) begin
        r_pulseCnt[i] <= r_pulseCnt[i] + PW'(1);
      end
    end

    // This decodes register state only. There is no combinational path from
    // the raw input.
    assign debounced_signal[i] = (r_pulseCnt[i] == PULSE_FULL);
  end

`ifdef DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] r_debouncedD;

  // This delayed copy of the filtered level is used for edge detection. Reset
  // clears both this copy and the level, so releasing reset never produces
  // an edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_debouncedD <= '0;
    end else begin
      r_debouncedD <= debounced_signal;
    end
  end

  assign rising_pulse  = debounced_signal & ~r_debouncedD;
  assign falling_pulse = ~debounced_signal & r_debouncedD;
`else
  assign rising_pulse  = '0;
  assign falling_pulse = '0;
`endif

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent input channels.
REQ-002 SHALL have parameter SAMPLE_CNT_MAX, default 62500: clock cycles per sample period; legal values are 2 or more.
REQ-003 SHALL have parameter PULSE_CNT_MAX, default 200: consecutive high samples needed to assert an output; legal values are 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port glitchy_signal, input, WIDTH bits: already synchronized to clk by the upstream two-flop synchronizer; not re-synchronized here.
REQ-007 SHALL have port debounced_signal, output, WIDTH bits: filtered level per channel.
REQ-008 SHALL have port rising_pulse, output, WIDTH bits: one-cycle pulse on each 0->1 transition of debounced_signal.
REQ-009 SHALL have port falling_pulse, output, WIDTH bits: one-cycle pulse on each 1->0 transition of debounced_signal.

Function
REQ-010 SHALL contain one shared sample counter sized to $clog2(SAMPLE_CNT_MAX) bits that increments every cycle from 0 to SAMPLE_CNT_MAX-1 and wraps to 0.
REQ-011 SHALL assert the internal sample_pulse combinationally while the sample counter equals SAMPLE_CNT_MAX-1, i.e. once every SAMPLE_CNT_MAX cycles.
REQ-012 SHALL hold one saturating counter per channel, sized to $clog2(PULSE_CNT_MAX+1) bits.
REQ-013 SHALL clear channel i's counter to 0 at the next edge on any cycle where glitchy_signal[i] is 0, whether or not sample_pulse is high; clear takes priority.
REQ-014 SHALL increment channel i's counter by 1 at the edge ending a cycle where sample_pulse is 1, glitchy_signal[i] is 1, and the counter is below PULSE_CNT_MAX.
REQ-015 SHALL hold channel i's counter at PULSE_CNT_MAX (saturate) while the input remains high.
REQ-016 SHALL drive debounced_signal[i] = (counter[i] == PULSE_CNT_MAX), decoded from registered state only, with no path from glitchy_signal.
REQ-017 SHALL deliver debounced_signal[i] low one cycle after glitchy_signal[i] goes low (release is not filtered).
REQ-018 SHALL keep a registered copy debounced_d of debounced_signal.
REQ-019 SHALL drive rising_pulse = debounced_signal & ~debounced_d and falling_pulse = ~debounced_signal & debounced_d, each exactly one cycle wide.
REQ-020 SHALL process all channels independently; the shared sample counter is the only cross-channel state.

Reset
REQ-021 SHALL, while rst is high, asynchronously clear the sample counter, all channel counters and debounced_d, so that debounced_signal, rising_pulse and falling_pulse are all 0.
REQ-022 SHALL on rst assertion mid-count discard accumulated samples; after release, counting restarts from 0 with no edge pulse generated by the reset itself.

Configuration
REQ-023 SHALL, when macro DEBOUNCER_EDGE_EN is defined, implement debounced_d and drive rising_pulse and falling_pulse per REQ-019.
REQ-024 SHALL, when DEBOUNCER_EDGE_EN is undefined, omit debounced_d and tie rising_pulse and falling_pulse to constant 0; debounced_signal is unchanged.

Verification (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, DEBOUNCER_EDGE_EN defined unless noted)
REQ-025 SHALL cover clean press: glitchy_signal=2'b01 held from rst release -> debounced_signal[0] rises at clock edge 12, rising_pulse[0] high for exactly cycle 12, and channel 1 stays 0 throughout.
REQ-026 SHALL cover glitch rejection: channel 0 high 10 cycles, low 1 cycle, then high -> no debounced_signal[0] assertion at edge 12; assertion occurs 3 full sample pulses after the low cycle.
REQ-027 SHALL cover release: with debounced_signal[0]=1, drive glitchy_signal[0]=0 -> debounced_signal[0]=0 one edge later and falling_pulse[0] high for exactly one cycle.
REQ-028 SHALL cover simultaneous events: input low in the same cycle that sample_pulse is high -> counter becomes 0, not incremented.
REQ-029 SHALL cover reset mid-operation: rst pulsed with both channels saturated -> all outputs 0 asynchronously, no falling_pulse after release, and re-assertion exactly 12 edges after release.
REQ-030 SHALL cover the macro-off build: repeat REQ-025 with DEBOUNCER_EDGE_EN undefined -> identical debounced_signal timing and rising_pulse/falling_pulse constantly 0.
